// File: rtl/pipe_reg_file_pkg.sv
// Shared constants and types for the pipelined register file.
// Holds the default geometry and a helper for address-width derivation.
package pipe_reg_file_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_PC_STEP  = 2;
  localparam int DEF_AW       = $clog2(DEF_NUM_REGS);

  // Register index at the default geometry.
  typedef logic [DEF_AW-1:0] reg_idx_t;

  // Address width for n registers; never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_reg_file_sb.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A write to a register clears its bit; a busy set wins over a same-cycle
// clear. Bit 0 can never be set, so it always reads 0.
module pipe_reg_file_sb
  import pipe_reg_file_pkg::*;
#(
  parameter int  NUM_REGS = DEF_NUM_REGS,
  localparam int AW       = addr_width(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REGS-1:0] i_clr,
  input  logic                i_set_en,
  input  logic [AW-1:0]       i_set_addr,
  output logic [NUM_REGS-1:0] o_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
    logic w_set;
    // Address 0 never matches a set, which keeps bit 0 permanently clear.
    assign w_set = i_set_en && (i_set_addr != '0) && (i_set_addr == AW'(gi));
    assign w_busy_next[gi] = w_set ? 1'b1 : (i_clr[gi] ? 1'b0 : r_busy[gi]);
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/pipe_reg_file.sv
// Multi-ported register file with an auto-incrementing program counter and
// an advisory busy scoreboard.
// Optional feature: define PIPE_REG_FILE_BYPASS_EN to forward same-cycle
// write data onto matching read ports; otherwise reads show stored state.
// Register 0 reads as zero; register PC_IDX is the PC and is kept in r_pc.
module pipe_reg_file
  import pipe_reg_file_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  NUM_REGS = DEF_NUM_REGS,
  parameter int  NUM_RD   = 2,
  parameter int  NUM_WR   = 2,
  parameter int  PC_IDX   = NUM_REGS - 1,
  parameter int  PC_STEP  = DEF_PC_STEP,
  localparam int AW       = addr_width(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     pc_wr_en,
  input  logic [DATA_W-1:0]        pc_wr_data,
  input  logic                     pc_hold,
  input  logic                     busy_set_en,
  input  logic [AW-1:0]            busy_set_addr,
  output logic [DATA_W-1:0]        pc_out,
  output logic [NUM_REGS-1:0]      busy
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   r_pc;

  logic [NUM_REGS-1:0] w_wr_hit;
  logic [DATA_W-1:0]   w_wr_val [NUM_REGS];
  logic                w_pc_load;
  logic [DATA_W-1:0]   w_pc_load_val;
  logic [DATA_W-1:0]   w_pc_next;

  // Per-register write resolution; ports are scanned upward so the
  // highest-numbered port writing an address wins. Address 0 is never hit.
  always_comb begin
    w_wr_hit = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      w_wr_val[n] = '0;
    end
    for (int p = 0; p < NUM_WR; p++) begin
      for (int n = 1; n < NUM_REGS; n++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(n))) begin
          w_wr_hit[n] = 1'b1;
          w_wr_val[n] = wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // PC next value: explicit load, then a port write to PC_IDX, then
  // auto-increment unless stalled. Addition wraps at DATA_W bits.
  always_comb begin
    w_pc_load     = 1'b0;
    w_pc_load_val = r_pc;
    if (pc_wr_en) begin
      w_pc_load     = 1'b1;
      w_pc_load_val = pc_wr_data;
    end else if (w_wr_hit[PC_IDX]) begin
      w_pc_load     = 1'b1;
      w_pc_load_val = w_wr_val[PC_IDX];
    end
    if (w_pc_load) begin
      w_pc_next = w_pc_load_val;
    end else if (!pc_hold) begin
      w_pc_next = r_pc + DATA_W'(PC_STEP);
    end else begin
      w_pc_next = r_pc;
    end
  end

  // General-purpose register storage; the PC slot lives in r_pc instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        r_regs[n] <= '0;
      end
    end else begin
      for (int n = 1; n < NUM_REGS; n++) begin
        if ((n != PC_IDX) && w_wr_hit[n]) begin
          r_regs[n] <= w_wr_val[n];
        end
      end
    end
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign pc_out = r_pc;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = rd_addr[gi*AW +: AW];

    // Combinational read mux: zero register and out-of-range addresses read 0.
    always_comb begin
      w_data = '0;
      if ((w_addr == '0) || (int'(w_addr) >= NUM_REGS)) begin
        w_data = '0;
      end else if (w_addr == AW'(PC_IDX)) begin
`ifdef PIPE_REG_FILE_BYPASS_EN
        w_data = w_pc_load ? w_pc_load_val : r_pc;
`else
        w_data = r_pc;
`endif
      end else begin
`ifdef PIPE_REG_FILE_BYPASS_EN
        w_data = w_wr_hit[w_addr] ? w_wr_val[w_addr] : r_regs[w_addr];
`else
        w_data = r_regs[w_addr];
`endif
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = w_data;
  end

  pipe_reg_file_sb #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_wr_hit),
    .i_set_en   (busy_set_en),
    .i_set_addr (busy_set_addr),
    .o_busy     (busy)
  );

endmodule
